// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: flag_type codes, opcode constants and instruction field positions.
// Used by both the instruction encoder and the decoder.
package cpu_isa_pkg;

    localparam logic [3:0] FT_R     = 4'b0001;
    localparam logic [3:0] FT_I     = 4'b0010;
    localparam logic [3:0] FT_LOAD  = 4'b0100;
    localparam logic [3:0] FT_STORE = 4'b0101;

    localparam logic [7:0] OP_LOAD  = 8'h85;
    localparam logic [7:0] OP_STORE = 8'h87;

    localparam logic [3:0] OP4_ADDI = 4'b0101;
    localparam logic [3:0] OP4_SUBI = 4'b1001;

    // Bit positions within the 16-bit instruction word
    localparam int OPC_MSB    = 15;
    localparam int OPC_LSB    = 8;
    localparam int OP4_LSB    = 12;
    localparam int RDST_LSB_R = 4;
    localparam int RDST_LSB_I = 8;
    localparam int RSRC_LSB   = 0;
    localparam int IMM_LSB    = 0;

    function automatic logic is_legal_r(input logic [7:0] op);
        case (op)
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
            8'h08, 8'h09, 8'h0B, 8'h0C, 8'h0F, 8'h84: is_legal_r = 1'b1;
            default:                                 is_legal_r = 1'b0;
        endcase
    endfunction

    function automatic logic is_legal_i(input logic [3:0] op4);
        is_legal_i = (op4 == OP4_ADDI) || (op4 == OP4_SUBI);
    endfunction

endpackage

// File: rtl/encoder_fifo.sv
// Small synchronous FIFO holding encoded words with their program address.
// Full/empty come from registered state only, so ready never depends on a same-cycle pop.
module encoder_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the top gates the head with empty
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 16-bit words tagged with a program address and buffers them.
// Optional legality checking is enabled by defining INSTR_ENCODER_CHECK_EN.
module instr_encoder
    import cpu_isa_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        opcode,
    input  logic [3:0]        rdst,
    input  logic [3:0]        rsrc,
    input  logic [7:0]        immediate,
    input  logic [3:0]        flag_type,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       raw_instructions,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    input  logic              err_clr
);

    localparam int ENTRY_W = 16 + ADDR_W;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  addr_cur;
    logic [15:0]        packed_word;
    logic               legal;
    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [ENTRY_W-1:0] head;

    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;

    always_comb begin
        packed_word = {opcode, rdst, rsrc};
        if (flag_type == FT_I) begin
            packed_word = {opcode[3:0], rdst, immediate};
        end
    end

`ifdef INSTR_ENCODER_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        legal = 1'b0;
        case (flag_type)
            FT_R:     legal = is_legal_r(opcode);
            FT_I:     legal = is_legal_i(opcode[3:0]);
            FT_LOAD:  legal = (opcode == OP_LOAD);
            FT_STORE: legal = (opcode == OP_STORE);
            default:  legal = 1'b0;
        endcase
    end

    // A new illegal event wins over a same-cycle clear
    always_comb begin
        err_d = err_q && !err_clr;
        if (accept && !legal) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_illegal = err_q;
`else
    logic unused_err_clr;

    assign legal          = 1'b1;
    assign err_illegal    = 1'b0;
    assign unused_err_clr = err_clr;
`endif

    // A load in the same cycle as an accepted word tags that word with start_addr
    always_comb begin
        addr_cur = addr_load ? start_addr : addr_q;
        addr_d   = addr_cur;
        if (push) begin
            addr_d = addr_cur + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    encoder_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({packed_word, addr_cur}),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign raw_instructions = out_valid ? head[ENTRY_W-1:ADDR_W] : 16'h0000;
    assign out_addr         = out_valid ? head[ADDR_W-1:0]       : '0;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed, table-driven bench for instr_encoder (default DEPTH=2, ADDR_W=16).
// Expectations adapt to whether INSTR_ENCODER_CHECK_EN is defined.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  opcode;
    logic [3:0]  rdst;
    logic [3:0]  rsrc;
    logic [7:0]  immediate;
    logic [3:0]  flag_type;
    logic        addr_load;
    logic [15:0] start_addr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] raw_instructions;
    logic [15:0] out_addr;
    logic        err_illegal;
    logic        err_clr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(16), .DEPTH(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .opcode           (opcode),
        .rdst             (rdst),
        .rsrc             (rsrc),
        .immediate        (immediate),
        .flag_type        (flag_type),
        .addr_load        (addr_load),
        .start_addr       (start_addr),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .raw_instructions (raw_instructions),
        .out_addr         (out_addr),
        .err_illegal      (err_illegal),
        .err_clr          (err_clr)
    );

    typedef struct {
        logic [3:0]  flag;
        logic [7:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [7:0]  imm;
        logic [15:0] word;
        logic        legal;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [3:0] f, input logic [7:0] op, input logic [3:0] rd,
                              input logic [3:0] rs, input logic [7:0] imm);
        flag_type = f;
        opcode    = op;
        rdst      = rd;
        rsrc      = rs;
        immediate = imm;
    endtask

    // One-cycle presentation of a field set; caller guarantees in_ready is high
    task automatic send(input logic [3:0] f, input logic [7:0] op, input logic [3:0] rd,
                        input logic [3:0] rs, input logic [7:0] imm,
                        input logic ld, input logic [15:0] sa);
        set_fields(f, op, rd, rs, imm);
        addr_load  = ld;
        start_addr = sa;
        in_valid   = 1'b1;
        step();
        in_valid  = 1'b0;
        addr_load = 1'b0;
    endtask

    // Waits (bounded) for a word at the head, compares, then lets it be popped (out_ready high)
    task automatic expect_word(input string name, input logic [15:0] w, input logic [15:0] a);
        int n = 0;
        while (!out_valid && n < 8) begin
            step();
            n++;
        end
        if (!out_valid) begin
            chk({name, "_timeout"}, 32'(out_valid), 32'd1);
        end else begin
            chk({name, "_word"}, 32'(raw_instructions), 32'(w));
            chk({name, "_addr"}, 32'(out_addr), 32'(a));
            step();
        end
    endtask

    logic        check_en;
    logic [15:0] exp_addr;
    logic        emit;

    initial begin
`ifdef INSTR_ENCODER_CHECK_EN
        check_en = 1'b1;
`else
        check_en = 1'b0;
`endif
        vecs[0] = '{4'b0001, 8'h05, 4'h3, 4'h7, 8'h00, 16'h0537, 1'b1};
        vecs[1] = '{4'b0010, 8'h05, 4'h2, 4'h0, 8'hFF, 16'h52FF, 1'b1};
        vecs[2] = '{4'b0101, 8'h87, 4'h1, 4'h4, 8'h00, 16'h8714, 1'b1};
        vecs[3] = '{4'b0100, 8'h85, 4'hA, 4'hB, 8'h00, 16'h85AB, 1'b1};
        vecs[4] = '{4'b0010, 8'hF9, 4'h0, 4'h0, 8'h3C, 16'h903C, 1'b1};
        vecs[5] = '{4'b0001, 8'h0A, 4'h1, 4'h2, 8'h00, 16'h0A12, 1'b0};
        vecs[6] = '{4'b0001, 8'h84, 4'hF, 4'h0, 8'h00, 16'h84F0, 1'b1};
        vecs[7] = '{4'b0010, 8'h03, 4'h4, 4'h0, 8'h11, 16'h3411, 1'b0};
        vecs[8] = '{4'b1000, 8'h05, 4'h6, 4'h6, 8'h00, 16'h0566, 1'b0};
        vecs[9] = '{4'b0100, 8'h86, 4'h1, 4'h2, 8'h00, 16'h8612, 1'b0};

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        addr_load = 1'b0;
        start_addr = 16'h0000;
        err_clr = 1'b0;
        set_fields(4'b0001, 8'h00, 4'h0, 4'h0, 8'h00);
        repeat (3) step();
        reset = 1'b0;

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_raw", 32'(raw_instructions), 32'h0);
        chk("rst_out_addr", 32'(out_addr), 32'h0);
        chk("rst_err", 32'(err_illegal), 32'd0);

        // First-word latency: visible on the cycle after acceptance
        out_ready = 1'b1;
        send(4'b0001, 8'h05, 4'h3, 4'h7, 8'h00, 1'b0, 16'h0);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        expect_word("first_add", 16'h0537, 16'h0000);
        chk("first_drained", 32'(out_valid), 32'd0);

        // addr_load together with an accepted word, buffer filled with consumer stalled
        out_ready = 1'b0;
        send(4'b0010, 8'h05, 4'h2, 4'h0, 8'hFF, 1'b1, 16'h0010);
        send(4'b0101, 8'h87, 4'h1, 4'h4, 8'h00, 1'b0, 16'h0);
        chk("ld_full_ready", 32'(in_ready), 32'd0);
        step();
        chk("ld_hold_word", 32'(raw_instructions), 32'h52FF);
        chk("ld_hold_addr", 32'(out_addr), 32'h0010);
        addr_load = 1'b1;
        start_addr = 16'h0040;
        step();
        addr_load = 1'b0;
        chk("ld_no_fifo_change", 32'(raw_instructions), 32'h52FF);
        out_ready = 1'b1;
        expect_word("ld_addi", 16'h52FF, 16'h0010);
        expect_word("ld_store", 16'h8714, 16'h0011);
        exp_addr = 16'h0040;

        for (int i = 0; i < 10; i++) begin
            emit = vecs[i].legal || !check_en;
            send(vecs[i].flag, vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm, 1'b0, 16'h0);
            if (emit) begin
                expect_word($sformatf("vec%0d", i), vecs[i].word, exp_addr);
                exp_addr = exp_addr + 16'd1;
                chk($sformatf("vec%0d_err", i), 32'(err_illegal), 32'd0);
            end else begin
                chk($sformatf("vec%0d_no_word", i), 32'(out_valid), 32'd0);
                chk($sformatf("vec%0d_err_set", i), 32'(err_illegal), 32'd1);
                step();
                chk($sformatf("vec%0d_err_sticky", i), 32'(err_illegal), 32'd1);
                err_clr = 1'b1;
                step();
                err_clr = 1'b0;
                chk($sformatf("vec%0d_err_clr", i), 32'(err_illegal), 32'd0);
            end
        end
        send(4'b0001, 8'h0C, 4'h5, 4'h5, 8'h00, 1'b0, 16'h0);
        expect_word("post_table", 16'h0C55, exp_addr);

        // Clear colliding with a new illegal event
        send(4'b0001, 8'h0A, 4'h0, 4'h0, 8'h00, 1'b0, 16'h0);
        err_clr = 1'b1;
        send(4'b0001, 8'h0A, 4'h0, 4'h0, 8'h00, 1'b0, 16'h0);
        chk("clr_collide_err", 32'(err_illegal), 32'(check_en));
        step();
        err_clr = 1'b0;
        chk("clr_after_err", 32'(err_illegal), 32'd0);
        while (out_valid) step();

        // Three sets into a two-entry buffer with the consumer stalled
        out_ready = 1'b0;
        addr_load = 1'b1;
        start_addr = 16'h0100;
        set_fields(4'b0001, 8'h01, 4'h1, 4'h1, 8'h00);
        in_valid = 1'b1;
        step();
        addr_load = 1'b0;
        set_fields(4'b0001, 8'h02, 4'h2, 4'h2, 8'h00);
        step();
        chk("bp_ready_low", 32'(in_ready), 32'd0);
        set_fields(4'b0001, 8'h03, 4'h3, 4'h3, 8'h00);
        step();
        chk("bp_third_held", 32'(in_ready), 32'd0);
        chk("bp_head_stable", 32'(raw_instructions), 32'h0111);
        out_ready = 1'b1;
        expect_word("bp_w1", 16'h0111, 16'h0100);
        chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
        expect_word("bp_w2", 16'h0222, 16'h0101);
        in_valid = 1'b0;
        expect_word("bp_w3", 16'h0333, 16'h0102);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Address wrap
        send(4'b0001, 8'h01, 4'h0, 4'h0, 8'h00, 1'b1, 16'hFFFF);
        expect_word("wrap_a", 16'h0100, 16'hFFFF);
        send(4'b0001, 8'h02, 4'h1, 4'h1, 8'h00, 1'b0, 16'h0);
        expect_word("wrap_b", 16'h0211, 16'h0000);

        // Reset with two words buffered dominates addr_load and err_clr
        out_ready = 1'b0;
        send(4'b0001, 8'h04, 4'h1, 4'h2, 8'h00, 1'b0, 16'h0);
        send(4'b0001, 8'h06, 4'h3, 4'h4, 8'h00, 1'b0, 16'h0);
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        reset = 1'b1;
        addr_load = 1'b1;
        start_addr = 16'h0055;
        err_clr = 1'b1;
        step();
        reset = 1'b0;
        addr_load = 1'b0;
        err_clr = 1'b0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_raw", 32'(raw_instructions), 32'h0);
        out_ready = 1'b1;
        send(4'b0001, 8'h03, 4'h2, 4'h3, 8'h00, 1'b0, 16'h0);
        expect_word("mid_rst_addr0", 16'h0323, 16'h0000);
        chk("mid_rst_no_stale", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 16, width of program address counter.
REQ-002 Parameter DEPTH, default 2, output buffer entries (power of two, >=2).
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  field set valid.
REQ-006 in_ready  out  1  encoder can accept field set this cycle.
REQ-007 opcode  in  8  opcode; I-type uses opcode[3:0] only.
REQ-008 rdst  in  4  destination register.
REQ-009 rsrc  in  4  source register.
REQ-010 immediate  in  8  I-type immediate.
REQ-011 flag_type  in  4  0001 R, 0010 I, 0100 load, 0101 store.
REQ-012 addr_load  in  1  load start_addr into address counter.
REQ-013 start_addr  in  ADDR_W  program base address.
REQ-014 out_valid  out  1  encoded word valid.
REQ-015 out_ready  in  1  consumer accepts word.
REQ-016 raw_instructions  out  16  encoded instruction word.
REQ-017 out_addr  out  ADDR_W  program address of raw_instructions.
REQ-018 err_illegal  out  1  sticky illegal-encoding flag.
REQ-019 err_clr  in  1  clears err_illegal.

Function
REQ-020 Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-021 Packing: R, load, store -> {opcode[7:0], rdst, rsrc}; I -> {opcode[3:0], rdst, immediate}.
REQ-022 Legal I opcodes: 4'b0101 addi, 4'b1001 subi.
REQ-023 Legal R opcodes: 0x01,0x02,0x03,0x04,0x05,0x06,0x07,0x08,0x09,0x0B,0x0C,0x0F,0x84; legal load 0x85; legal store 0x87.
REQ-024 Accepted word enqueued into DEPTH-entry FIFO with current address; address counter then increments by 1, wrapping 2^ADDR_W-1 -> 0.
REQ-025 Latency: field set accepted at edge N appears on out_valid after edge N (next cycle) when FIFO was empty.
REQ-026 in_ready = FIFO not full; combinational from state only, never from in_valid.
REQ-027 Simultaneous push and pop with FIFO non-empty and not full: count unchanged, order preserved.
REQ-028 Full FIFO: in_ready low; pop same cycle does not enable a push that cycle.
REQ-029 Output holds raw_instructions/out_addr stable while out_valid && !out_ready.
REQ-030 addr_load with simultaneous accepted input: accepted word uses start_addr; counter becomes start_addr+1.
REQ-031 addr_load does not alter FIFO contents.
REQ-032 err_clr and a new illegal event in the same cycle: err_illegal remains 1.

Reset
REQ-033 reset: FIFO empty, out_valid 0, in_ready 1, address counter 0, err_illegal 0, raw_instructions 16'h0000, out_addr 0.
REQ-034 reset mid-transfer: buffered words discarded, no partial output; reset dominates addr_load and err_clr.

Configuration
REQ-035 Macro INSTR_ENCODER_CHECK_EN defined: illegal flag_type/opcode combination is accepted (in_ready handshake completes), not enqueued, address not incremented, err_illegal set next cycle.
REQ-036 Macro undefined: no legality check; unknown flag_type packed as R-type; err_illegal tied 0; err_clr ignored.

Structure
REQ-037 Shared package cpu_isa_pkg holds flag_type codes, opcode constants, I-type op4 constants, field bit positions; same package used by the decoder.
REQ-038 One sub-module encoder_fifo (DEPTH x (16+ADDR_W), count, full/empty); packing and legality logic in instr_encoder.

Verification
REQ-039 After reset, send R add (opcode 0x05, rdst 3, rsrc 7), out_ready 1 -> next cycle raw_instructions 16'h0537, out_addr 0.
REQ-040 addr_load start_addr 0x0010, send addi (opcode 0x05, rdst 2, imm 0xFF) then store (0x87, rdst 1, rsrc 4) -> words 16'h52FF @0x0010, 16'h8714 @0x0011.
REQ-041 out_ready 0, send 3 sets -> in_ready low after 2 accepts, third held; out_ready 1 -> all three emitted in order, addresses consecutive.
REQ-042 ADDR_W 16, start_addr 0xFFFF, send 2 sets -> out_addr 0xFFFF then 0x0000.
REQ-043 With INSTR_ENCODER_CHECK_EN, send R opcode 0x0A -> no output word, address unchanged, err_illegal 1 until err_clr; without macro -> word 16'h0A.. emitted, err_illegal 0.
REQ-044 Reset asserted with 2 words buffered -> next cycle out_valid 0, in_ready 1, address 0.
